// File: rtl/wavelet_accelerator_csr_bank.sv
`default_nettype none
// wavelet_accelerator_csr_bank: host byte-addressed CSRs with a go/init/done FSM per core.
// Define WAVELET_CSR_IRQ_EN to enable byte 3 (irq_en / irq_flag) and the irq output.
module wavelet_accelerator_csr_bank #(
  parameter int PACKET_WIDTH = 8,
  parameter int NUM_CORES    = 2,
  parameter int SEL_W        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     rd_en,
  input  logic [SEL_W-1:0]         core_sel,
  input  logic [1:0]               byte_offset,
  input  logic [PACKET_WIDTH-1:0]  data_in,
  output logic [PACKET_WIDTH-1:0]  rd_data,
  output logic                     rd_valid,
  input  logic [NUM_CORES-1:0]     core_clear_go,
  input  logic [NUM_CORES-1:0]     core_clear_init,
  input  logic [NUM_CORES-1:0]     core_r_data_available,
  output logic [NUM_CORES-1:0]     core_go,
  output logic [NUM_CORES-1:0]     core_init,
  output logic [NUM_CORES-1:0]     core_r_addr_rst,
  output logic [2*NUM_CORES-1:0]   core_inputs_len,
  output logic [2*NUM_CORES-1:0]   core_dec_level,
  output logic [5*NUM_CORES-1:0]   core_filter_size,
  output logic                     irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  logic [7:0]              rd_byte [NUM_CORES];
  logic [PACKET_WIDTH-1:0] rd_mux;
  logic                    unused_data;

  assign unused_data = ^data_in[PACKET_WIDTH-1:7];

`ifdef WAVELET_CSR_IRQ_EN
  logic [NUM_CORES-1:0] pend;
`endif

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    localparam logic [SEL_W-1:0] ID = SEL_W'(i);

    state_t     state, state_nxt;
    logic       go, init, addr_rst, ready, avail_q;
    logic [1:0] len, lvl;
    logic [4:0] fsize;
    logic [7:0] byte3, rb;
    logic       sel, wr0, wr1, cfg_ok, rise, fall, init_ok, go_ok;
    logic       clr_go, clr_init, avail;

    assign clr_go   = core_clear_go[i];
    assign clr_init = core_clear_init[i];
    assign avail    = core_r_data_available[i];
    assign sel      = (core_sel == ID);
    assign wr0      = en && sel && (byte_offset == 2'd0);
    assign wr1      = en && sel && (byte_offset == 2'd1);
    assign cfg_ok   = (state == IDLE) || (state == DONE);
    assign rise     = avail && !avail_q;
    assign fall     = !avail && avail_q;
    // Go and init together in IDLE: init is taken, go is dropped (and counted as an error).
    assign init_ok  = wr0 && data_in[1] && (state == IDLE);
    assign go_ok    = wr0 && data_in[0] && ((state == DONE) || ((state == IDLE) && !data_in[1]));

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE: begin
          if (init_ok && !clr_init)   state_nxt = INIT;
          else if (go_ok && !clr_go)  state_nxt = RUN;
        end
        INIT: if (clr_init) state_nxt = IDLE;
        RUN:  if (clr_go)   state_nxt = DONE;
        DONE: begin
          if (go_ok && !clr_go)       state_nxt = RUN;
          else if (fall)              state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        go       <= 1'b0;
        init     <= 1'b0;
        addr_rst <= 1'b0;
        ready    <= 1'b0;
        avail_q  <= 1'b0;
        len      <= 2'b00;
        lvl      <= 2'b00;
        fsize    <= 5'd0;
      end else begin
        avail_q  <= avail;
        addr_rst <= wr0 && data_in[2];
        if (rise)          ready <= 1'b1;
        else if (fall)     ready <= 1'b0;
        // Hardware clear beats a simultaneous host set.
        if (clr_go)        go    <= 1'b0;
        else if (go_ok)    go    <= 1'b1;
        if (clr_init)      init  <= 1'b0;
        else if (init_ok)  init  <= 1'b1;
        if (wr0 && cfg_ok) begin
          len <= data_in[4:3];
          lvl <= data_in[6:5];
        end
        if (wr1 && cfg_ok) fsize <= data_in[4:0];
      end
    end

`ifdef WAVELET_CSR_IRQ_EN
    logic [1:0] flag, irq_en_q, flag_set, flag_clr;
    logic       wr3, err;

    assign wr3      = en && sel && (byte_offset == 2'd3);
    assign err      = wr0 && ((data_in[1] && !init_ok) || (data_in[0] && !go_ok));
    assign flag_set = {err, (state == RUN) && clr_go};
    assign flag_clr = wr3 ? data_in[1:0] : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        flag     <= 2'b00;
        irq_en_q <= 2'b00;
      end else begin
        flag <= flag_set | (flag & ~flag_clr);
        if (wr3) irq_en_q <= data_in[5:4];
      end
    end

    assign byte3   = {2'b00, irq_en_q, 2'b00, flag};
    assign pend[i] = |(flag & irq_en_q);
`else
    assign byte3 = 8'h00;
`endif

    always_comb begin
      case (byte_offset)
        2'd0:    rb = {ready, lvl, len, addr_rst, init, go};
        2'd1:    rb = {3'b000, fsize};
        2'd2:    rb = {6'b000000, state};
        default: rb = byte3;
      endcase
    end

    assign rd_byte[i]                 = sel ? rb : 8'h00;
    assign core_go[i]                 = go;
    assign core_init[i]               = init;
    assign core_r_addr_rst[i]         = addr_rst;
    assign core_inputs_len[2*i +: 2]  = len;
    assign core_dec_level[2*i +: 2]   = lvl;
    assign core_filter_size[5*i +: 5] = fsize;
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CORES; k++) rd_mux[7:0] = rd_mux[7:0] | rd_byte[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_mux : '0;
    end
  end

`ifdef WAVELET_CSR_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= |pend;
  end
`else
  assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wavelet_accelerator_csr_bank.sv
`default_nettype none
// Testbench for wavelet_accelerator_csr_bank: directed scenarios plus random traffic
// checked every cycle against a behavioural per-core register model.
module tb_wavelet_accelerator_csr_bank;
  localparam int PW = 8;
  localparam int NC = 2;
  localparam int SW = 1;
  localparam int S_IDLE = 0, S_INIT = 1, S_RUN = 2, S_DONE = 3;
`ifdef WAVELET_CSR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, rd_en = 1'b0;
  logic [SW-1:0] core_sel = '0;
  logic [1:0]    byte_offset = 2'd0;
  logic [PW-1:0] data_in = '0;
  logic [NC-1:0] core_clear_go = '0, core_clear_init = '0, core_r_data_available = '0;
  logic [PW-1:0] rd_data;
  logic          rd_valid, irq;
  logic [NC-1:0] core_go, core_init, core_r_addr_rst;
  logic [2*NC-1:0] core_inputs_len, core_dec_level;
  logic [5*NC-1:0] core_filter_size;

  int total = 0, bad = 0;

  int m_go[NC], m_init[NC], m_rar[NC], m_len[NC], m_lvl[NC], m_fs[NC];
  int m_ready[NC], m_hist[NC], m_state[NC], m_flag[NC], m_ien[NC];
  int m_rdv, m_rdd, m_irq;

  wavelet_accelerator_csr_bank #(.PACKET_WIDTH(PW), .NUM_CORES(NC), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en), .core_sel(core_sel),
    .byte_offset(byte_offset), .data_in(data_in), .rd_data(rd_data), .rd_valid(rd_valid),
    .core_clear_go(core_clear_go), .core_clear_init(core_clear_init),
    .core_r_data_available(core_r_data_available), .core_go(core_go), .core_init(core_init),
    .core_r_addr_rst(core_r_addr_rst), .core_inputs_len(core_inputs_len),
    .core_dec_level(core_dec_level), .core_filter_size(core_filter_size), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_go[c] = 0; m_init[c] = 0; m_rar[c] = 0; m_len[c] = 0; m_lvl[c] = 0; m_fs[c] = 0;
      m_ready[c] = 0; m_hist[c] = 0; m_state[c] = S_IDLE; m_flag[c] = 0; m_ien[c] = 0;
    end
    m_rdv = 0; m_rdd = 0; m_irq = 0;
  endtask

  function automatic int model_read(int c, int off);
    if (c >= NC) return 0;
    case (off)
      0: return m_ready[c] * 128 + m_lvl[c] * 32 + m_len[c] * 8 + m_rar[c] * 4 + m_init[c] * 2 + m_go[c];
      1: return m_fs[c];
      2: return m_state[c];
      default: return IRQ_ON ? (m_ien[c] * 16 + m_flag[c]) : 0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs present at this edge.
  task automatic model_clock();
    logic [7:0] d;
    int  s, off, any;
    bit  wr, cg, ci, av, rise, fall, want_go, want_init, go_ok, init_ok, err, done_ev;
    d   = data_in[7:0];
    off = int'(byte_offset);
    any = 0;
    for (int c = 0; c < NC; c++) if ((m_flag[c] & m_ien[c]) != 0) any = 1;
    m_irq = IRQ_ON ? any : 0;
    m_rdv = rd_en;
    m_rdd = rd_en ? model_read(int'(core_sel), off) : 0;
    for (int c = 0; c < NC; c++) begin
      s  = m_state[c];
      wr = en && (int'(core_sel) == c);
      cg = core_clear_go[c]; ci = core_clear_init[c]; av = core_r_data_available[c];
      rise = av && (m_hist[c] == 0);
      fall = !av && (m_hist[c] != 0);
      want_go   = wr && off == 0 && d[0];
      want_init = wr && off == 0 && d[1];
      init_ok   = want_init && s == S_IDLE;
      go_ok     = want_go && (s == S_DONE || (s == S_IDLE && !want_init));
      err       = (want_init && !init_ok) || (want_go && !go_ok);
      done_ev   = (s == S_RUN) && cg;
      case (s)
        S_IDLE: if (init_ok && !ci) m_state[c] = S_INIT; else if (go_ok && !cg) m_state[c] = S_RUN;
        S_INIT: if (ci) m_state[c] = S_IDLE;
        S_RUN:  if (cg) m_state[c] = S_DONE;
        default: if (go_ok && !cg) m_state[c] = S_RUN; else if (fall) m_state[c] = S_IDLE;
      endcase
      if (cg) m_go[c] = 0; else if (go_ok) m_go[c] = 1;
      if (ci) m_init[c] = 0; else if (init_ok) m_init[c] = 1;
      m_rar[c] = (wr && off == 0 && d[2]) ? 1 : 0;
      if (wr && off == 0 && (s == S_IDLE || s == S_DONE)) begin
        m_len[c] = int'(d[4:3]); m_lvl[c] = int'(d[6:5]);
      end
      if (wr && off == 1 && (s == S_IDLE || s == S_DONE)) m_fs[c] = int'(d[4:0]);
      if (rise) m_ready[c] = 1; else if (fall) m_ready[c] = 0;
      m_hist[c] = av;
      if (IRQ_ON) begin
        m_flag[c] = (m_flag[c] & ~((wr && off == 3) ? int'(d[1:0]) : 0)) | (done_ev ? 1 : 0) | (err ? 2 : 0);
        if (wr && off == 3) m_ien[c] = int'(d[5:4]);
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("go%0d", c),   core_go[c],               m_go[c]);
      check($sformatf("init%0d", c), core_init[c],             m_init[c]);
      check($sformatf("rar%0d", c),  core_r_addr_rst[c],       m_rar[c]);
      check($sformatf("len%0d", c),  core_inputs_len[2*c +: 2], m_len[c]);
      check($sformatf("lvl%0d", c),  core_dec_level[2*c +: 2],  m_lvl[c]);
      check($sformatf("fs%0d", c),   core_filter_size[5*c +: 5], m_fs[c]);
    end
    check("rd_valid", rd_valid, m_rdv);
    if (m_rdv != 0) check("rd_data", rd_data, m_rdd);
    check("irq", irq, m_irq);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_go"}, core_go, 0);
    check({tag, "_init"}, core_init, 0);
    check({tag, "_rar"}, core_r_addr_rst, 0);
    check({tag, "_len"}, core_inputs_len, 0);
    check({tag, "_lvl"}, core_dec_level, 0);
    check({tag, "_fs"}, core_filter_size, 0);
    check({tag, "_rdv"}, rd_valid, 0);
    check({tag, "_rdd"}, rd_data, 0);
    check({tag, "_irq"}, irq, 0);
  endtask

  task automatic host_write(input int c, input int off, input int d);
    en = 1'b1; core_sel = SW'(c); byte_offset = 2'(off); data_in = PW'(d);
    cycle();
    en = 1'b0;
  endtask

  task automatic host_read(input string tag, input int c, input int off, input int exp);
    rd_en = 1'b1; core_sel = SW'(c); byte_offset = 2'(off);
    cycle();
    rd_en = 1'b0;
    check(tag, rd_data, exp);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Core 1 configure + init, then hardware clear of init.
    host_write(1, 1, 8'h0C);
    host_write(1, 0, 8'h2A);
    check("init1_set", core_init[1], 1);
    check("fs1", core_filter_size[9:5], 12);
    check("len1", core_inputs_len[3:2], 1);
    check("lvl1", core_dec_level[3:2], 1);
    host_read("state1_init", 1, 2, S_INIT);
    host_write(1, 1, 8'h03);
    check("fs1_locked_init", core_filter_size[9:5], 12);
    core_clear_init = 2'b10; cycle(); core_clear_init = '0;
    check("init1_clr", core_init[1], 0);
    host_read("state1_idle", 1, 2, S_IDLE);

    // Core 0 go -> RUN -> DONE with completion flag.
    host_write(0, 3, 8'h10);
    host_write(0, 0, 8'h01);
    check("go0_set", core_go[0], 1);
    host_read("state0_run", 0, 2, S_RUN);
    host_write(0, 1, 8'h1F);
    check("fs0_locked_run", core_filter_size[4:0], 0);
    core_clear_go = 2'b01; cycle(); core_clear_go = '0;
    check("go0_clr", core_go[0], 0);
    host_read("byte3_done", 0, 3, IRQ_ON ? 8'h11 : 8'h00);
    check("irq_done", irq, IRQ_ON);
    host_read("state0_done", 0, 2, S_DONE);

    // ready follows core_r_data_available edges; falling edge returns DONE to IDLE.
    core_r_data_available = 2'b01; cycle();
    host_read("ready_hi", 0, 0, 8'h80);
    host_read("still_done", 0, 2, S_DONE);
    core_r_data_available = 2'b00; cycle();
    host_read("ready_lo", 0, 0, 8'h00);
    host_read("state0_idle", 0, 2, S_IDLE);

    host_write(0, 3, 8'h11);
    cycle();
    check("irq_cleared", irq, 0);
    host_read("byte3_w1c", 0, 3, IRQ_ON ? 8'h10 : 8'h00);

    // go+init together in IDLE.
    host_write(0, 0, 8'h03);
    check("init0_both", core_init[0], 1);
    check("go0_both", core_go[0], 0);
    host_read("byte3_err", 0, 3, IRQ_ON ? 8'h12 : 8'h00);
    host_write(0, 3, 8'h12);
    host_read("byte3_errclr", 0, 3, IRQ_ON ? 8'h10 : 8'h00);
    core_clear_init = 2'b01; cycle(); core_clear_init = '0;
    host_read("state0_idle2", 0, 2, S_IDLE);

    // r_addr_rst pulse and clear-vs-set priority.
    host_write(0, 0, 8'h04);
    check("rar_hi", core_r_addr_rst[0], 1);
    cycle();
    check("rar_lo", core_r_addr_rst[0], 0);
    en = 1'b1; core_sel = '0; byte_offset = 2'd0; data_in = 8'h01; core_clear_go = 2'b01;
    cycle();
    en = 1'b0; core_clear_go = '0;
    check("go_clr_wins", core_go[0], 0);

    // Asynchronous reset in the middle of RUN.
    host_write(0, 1, 8'h09);
    host_write(0, 0, 8'h01);
    check("go0_run2", core_go[0], 1);
    rd_en = 1'b1; core_sel = '0; byte_offset = 2'd2; cycle(); rd_en = 1'b0;
    #3 rst = 1'b0;
    #1 check_zero("midrun");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    host_read("state0_after_rst", 0, 2, S_IDLE);

    // Read/write collision returns pre-write data.
    en = 1'b1; rd_en = 1'b1; core_sel = SW'(1); byte_offset = 2'd1; data_in = 8'h05;
    cycle();
    en = 1'b0; rd_en = 1'b0;
    check("collide_old", rd_data, 0);
    host_read("collide_new", 1, 1, 5);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      en          = ($urandom_range(0, 2) == 0);
      rd_en       = ($urandom_range(0, 1) == 0);
      core_sel    = SW'($urandom_range(0, NC - 1));
      byte_offset = 2'($urandom_range(0, 3));
      data_in     = PW'($urandom);
      for (int c = 0; c < NC; c++) begin
        core_clear_go[c]   = ($urandom_range(0, 5) == 0);
        core_clear_init[c] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 7) == 0) core_r_data_available[c] = ~core_r_data_available[c];
      end
      cycle();
    end
    en = 1'b0; rd_en = 1'b0; core_clear_go = '0; core_clear_init = '0;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wavelet_accelerator_csr_bank.md
WAVELET_ACCELERATOR_CSR_BANK -- requirements
Module: wavelet_accelerator_csr_bank

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 8, host write/read byte width; only bits [7:0] carry meaning, upper bits write-ignored and read 0.
REQ-002 SHALL have parameter NUM_CORES, default 2, number of independent core register sets (1..8).
REQ-003 SHALL have parameter SEL_W, default 1, core-select width, equal to max(1, clog2(NUM_CORES)).
REQ-004 SHALL have ports: clk input 1, single clock; rst input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: en input 1, host write strobe; rd_en input 1, host read strobe; core_sel input SEL_W; byte_offset input 2; data_in input PACKET_WIDTH.
REQ-006 SHALL have ports: rd_data output PACKET_WIDTH, rd_valid output 1.
REQ-007 SHALL have per-core input vectors of width NUM_CORES: core_clear_go, core_clear_init, core_r_data_available.
REQ-008 SHALL have per-core output vectors: core_go, core_init, core_r_addr_rst (NUM_CORES each); core_inputs_len, core_dec_level (2*NUM_CORES); core_filter_size (5*NUM_CORES); core i occupies slice i.
REQ-009 SHALL have port irq output 1, level interrupt.

Function
REQ-010 SHALL use this byte map per core: 0 = {ready, dec_level[1:0], inputs_len[1:0], r_addr_rst, init, go}; 1 = {000, filter_size[4:0]}; 2 = {000000, state[1:0]}, read-only; 3 = {00, irq_en[1:0], 00, irq_flag[1:0]}.
REQ-011 SHALL ignore writes with core_sel >= NUM_CORES; reads there return 0.
REQ-012 SHALL never let the host write ready; it is set on the rising edge and cleared on the falling edge of core_r_data_available, one cycle after the edge.
REQ-013 SHALL ignore writes to inputs_len, dec_level and filter_size while state is INIT or RUN.
REQ-014 SHALL keep go and init set until core_clear_go / core_clear_init; a hardware clear in the same cycle as a host write of the same bit wins.
REQ-015 SHALL assert r_addr_rst for exactly one cycle after a write with data_in[2]=1, then self-clear.
REQ-016 SHALL run per-core FSM state: IDLE=0, INIT=1, RUN=2, DONE=3.
REQ-017 SHALL take these transitions: IDLE, init written -> INIT; INIT, core_clear_init -> IDLE; IDLE or DONE, go written -> RUN; RUN, core_clear_go -> DONE; DONE, ready falling edge -> IDLE.
REQ-018 SHALL, on a write with go=1 and init=1 in IDLE, accept init, ignore go and flag error.
REQ-019 SHALL ignore a go or init write outside the states allowed in REQ-017 and flag error.
REQ-020 SHALL return rd_data with rd_valid high for one cycle, exactly one cycle after rd_en; reads have no side effects.
REQ-021 SHALL give an en/rd_en collision at the same address pre-write data on the read.

Reset
REQ-022 SHALL clear all registers, FSMs (IDLE), ready, edge-detect history, flags, enables, rd_data, rd_valid and irq to 0 on rst low, regardless of clk.
REQ-023 SHALL start edge detection from a history value of 0 after reset release; core_r_data_available high at release counts as a rising edge.

Configuration
REQ-024 SHALL, when WAVELET_CSR_IRQ_EN is defined, set irq_flag[0] on RUN->DONE and irq_flag[1] on error.
REQ-025 SHALL, with WAVELET_CSR_IRQ_EN defined, clear flags write-1-to-clear; a set event in the same cycle wins.
REQ-026 SHALL, with WAVELET_CSR_IRQ_EN defined, make irq_en read/write and drive irq as a register of OR over cores of (irq_flag & irq_en), one cycle behind the flag.
REQ-027 SHALL, when WAVELET_CSR_IRQ_EN is undefined, read byte 3 as 0, ignore writes to it, tie irq to 0 and remove flag logic; the rest is unchanged.

Verification
REQ-028 SHALL cover: core 1, write byte1=0x0C, byte0=0x2A (init, len=1, lvl=1) -> core_init[1]=1, state=1; core_clear_init[1] pulse -> init=0, state=0; filter_size[9:5]=12.
REQ-029 SHALL cover: core 0 IDLE, write byte0=0x01 -> go=1, RUN; write byte1=0x1F while RUN -> filter_size unchanged; core_clear_go[0] -> DONE, irq_flag=01, irq=1 if irq_en=01.
REQ-030 SHALL cover: write byte0=0x03 in IDLE -> init=1, go=0, irq_flag[1]=1; write byte3=0x02 -> flag cleared.
REQ-031 SHALL cover: core_r_data_available 0->1->0 -> ready reads 1 then 0; DONE -> IDLE on the falling edge.
REQ-032 SHALL cover: write byte0=0x04 -> core_r_addr_rst high exactly one cycle; same-cycle core_clear_go and go write -> go=0.
REQ-033 SHALL cover: rst low mid-RUN -> all outputs 0 asynchronously, state=IDLE.
